// File: rtl/change_dispense_ctrl_pkg.sv
// Shared definitions for the change dispenser: coin count, default coin values
// and the controller state encoding.
package change_dispense_ctrl_pkg;

  localparam int kNumCoins = 3;

  localparam int kCoin0ValDef = 100;
  localparam int kCoin1ValDef = 500;
  localparam int kCoin2ValDef = 1000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/change_dispense_ctrl_picker.sv
// Greedy coin selector: largest non-empty denomination that still fits in the
// remaining amount, returned as a one-hot select plus a found flag.
module coin_picker
  import change_dispense_ctrl_pkg::*;
#(
  parameter int BAL_W     = 16,
  parameter int COIN0_VAL = kCoin0ValDef,
  parameter int COIN1_VAL = kCoin1ValDef,
  parameter int COIN2_VAL = kCoin2ValDef
) (
  input  logic [BAL_W-1:0]     remaining,
  input  logic [kNumCoins-1:0] coin_empty,
  output logic [kNumCoins-1:0] sel,
  output logic                 found
);

  localparam logic [BAL_W-1:0] V0 = BAL_W'(COIN0_VAL);
  localparam logic [BAL_W-1:0] V1 = BAL_W'(COIN1_VAL);
  localparam logic [BAL_W-1:0] V2 = BAL_W'(COIN2_VAL);

  // Priority runs from the largest coin down.
  always_comb begin
    sel = '0;
    if (!coin_empty[2] && (remaining >= V2)) begin
      sel[2] = 1'b1;
    end else if (!coin_empty[1] && (remaining >= V1)) begin
      sel[1] = 1'b1;
    end else if (!coin_empty[0] && (remaining >= V0)) begin
      sel[0] = 1'b1;
    end
  end

  assign found = |sel;

endmodule

// File: rtl/change_dispense_ctrl.sv
// Returns a balance as individual coins, one per hopper handshake, using
// greedy largest-first selection and skipping empty hoppers.
module change_dispense_ctrl
  import change_dispense_ctrl_pkg::*;
#(
  parameter int BAL_W     = 16,
  parameter int COIN0_VAL = kCoin0ValDef,
  parameter int COIN1_VAL = kCoin1ValDef,
  parameter int COIN2_VAL = kCoin2ValDef
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic [BAL_W-1:0]     i_balance,
  input  logic [kNumCoins-1:0] i_coin_empty,
  input  logic                 i_hopper_ready,
  output logic                 o_coin_valid,
  output logic [kNumCoins-1:0] o_coin_sel,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_short,
  output logic [BAL_W-1:0]     o_remaining
);

  localparam logic [BAL_W-1:0] V0 = BAL_W'(COIN0_VAL);
  localparam logic [BAL_W-1:0] V1 = BAL_W'(COIN1_VAL);
  localparam logic [BAL_W-1:0] V2 = BAL_W'(COIN2_VAL);

  state_t               state, state_nxt;
  logic [BAL_W-1:0]     remaining;
  logic [kNumCoins-1:0] sel;
  logic                 short_flag;

  logic [kNumCoins-1:0] pick_sel;
  logic                 pick_found;
  logic [BAL_W-1:0]     sel_val;
  logic [BAL_W-1:0]     rem_after;

  coin_picker #(
    .BAL_W     (BAL_W),
    .COIN0_VAL (COIN0_VAL),
    .COIN1_VAL (COIN1_VAL),
    .COIN2_VAL (COIN2_VAL)
  ) u_picker (
    .remaining  (remaining),
    .coin_empty (i_coin_empty),
    .sel        (pick_sel),
    .found      (pick_found)
  );

  always_comb begin
    sel_val = '0;
    if (sel[2]) sel_val = V2;
    if (sel[1]) sel_val = V1;
    if (sel[0]) sel_val = V0;
  end

  // The picker only offers coins that fit, so this cannot underflow.
  assign rem_after = remaining - sel_val;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_start) state_nxt = (i_balance == '0) ? ST_DONE : ST_SELECT;
      end
      ST_SELECT: begin
        state_nxt = pick_found ? ST_DISPENSE : ST_DONE;
      end
      ST_DISPENSE: begin
        if (i_hopper_ready) state_nxt = (rem_after == '0) ? ST_DONE : ST_SELECT;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Remaining, select and short flag persist in IDLE until the next start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      remaining  <= '0;
      sel        <= '0;
      short_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            remaining  <= i_balance;
            short_flag <= 1'b0;
          end
        end
        ST_SELECT: begin
          if (pick_found) sel        <= pick_sel;
          else            short_flag <= 1'b1;
        end
        ST_DISPENSE: begin
          if (i_hopper_ready) remaining <= rem_after;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_coin_valid = (state == ST_DISPENSE);
    o_coin_sel   = (state == ST_DISPENSE) ? sel : '0;
    o_busy       = (state != ST_IDLE);
    o_done       = (state == ST_DONE);
    o_short      = short_flag;
    o_remaining  = remaining;
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: a greedy reference model queues the
// expected coins and end-of-sequence results, which are popped as the DUT emits them.
module tb_change_dispense_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start;
  logic [15:0] i_balance;
  logic [2:0]  i_coin_empty;
  logic        i_hopper_ready;
  logic        o_coin_valid;
  logic [2:0]  o_coin_sel;
  logic        o_busy;
  logic        o_done;
  logic        o_short;
  logic [15:0] o_remaining;

  change_dispense_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_start        (i_start),
    .i_balance      (i_balance),
    .i_coin_empty   (i_coin_empty),
    .i_hopper_ready (i_hopper_ready),
    .o_coin_valid   (o_coin_valid),
    .o_coin_sel     (o_coin_sel),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_short        (o_short),
    .o_remaining    (o_remaining)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    int         cyc;
  } coin_exp_t;

  typedef struct {
    logic        short_flag;
    logic [15:0] rem;
    int          cyc;
  } done_exp_t;

  coin_exp_t coin_q[$];
  done_exp_t done_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference greedy model; cycle expectations only when ready stays high.
  task automatic expect_seq(input int bal, input logic [2:0] empty, input bit timed);
    int vals[3];
    int rem;
    int t;
    int k;
    bit shrt;
    coin_exp_t ce;
    done_exp_t de;
    vals[0] = 100; vals[1] = 500; vals[2] = 1000;
    rem  = bal;
    t    = cyc + 2;
    shrt = 1'b0;
    while (rem > 0) begin
      k = -1;
      for (int i = 2; i >= 0; i--) begin
        if (k < 0 && !empty[i] && vals[i] <= rem) k = i;
      end
      if (k < 0) begin
        shrt = 1'b1;
        break;
      end
      ce.sel = 3'b001 << k;
      ce.cyc = timed ? t : -1;
      coin_q.push_back(ce);
      rem -= vals[k];
      t   += 2;
    end
    de.short_flag = shrt;
    de.rem        = 16'(rem);
    if (bal == 0)  de.cyc = cyc + 1;
    else if (shrt) de.cyc = t;
    else           de.cyc = t - 1;
    if (!timed) de.cyc = -1;
    done_q.push_back(de);
  endtask

  // Checks the current cycle's outputs against the queues, then advances one clock.
  task automatic cycle();
    coin_exp_t ce;
    done_exp_t de;
    if (reset_n && o_coin_valid === 1'b1 && i_hopper_ready) begin
      if (coin_q.size() == 0) chk("unexpected_coin", 32'(o_coin_sel), 0);
      else begin
        ce = coin_q.pop_front();
        chk("coin_sel", 32'(o_coin_sel), 32'(ce.sel));
        if (ce.cyc >= 0) chk("coin_cycle", cyc, ce.cyc);
      end
    end
    if (reset_n && o_done === 1'b1) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        de = done_q.pop_front();
        chk("done_short", 32'(o_short), 32'(de.short_flag));
        chk("done_remaining", 32'(o_remaining), 32'(de.rem));
        if (de.cyc >= 0) chk("done_cycle", cyc, de.cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_done(input int max_cycles);
    int n = 0;
    while ((coin_q.size() + done_q.size()) > 0 && n < max_cycles) begin
      cycle();
      n++;
    end
    chk("seq_complete", 32'(coin_q.size() + done_q.size()), 0);
    coin_q.delete();
    done_q.delete();
  endtask

  task automatic start_seq(input int bal, input logic [2:0] empty, input bit timed);
    i_balance    = 16'(bal);
    i_coin_empty = empty;
    i_start      = 1'b1;
    expect_seq(bal, empty, timed);
    cycle();
    i_start = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    i_start        = 1'b0;
    i_balance      = '0;
    i_coin_empty   = '0;
    i_hopper_ready = 1'b1;
    cycle();
    cycle();
    chk("rst_valid", 32'(o_coin_valid), 0);
    chk("rst_sel", 32'(o_coin_sel), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_short", 32'(o_short), 0);
    chk("rst_remaining", 32'(o_remaining), 0);
    reset_n = 1'b1;
    cycle();

    // 1600 with every hopper stocked: 1000, 500, 100
    start_seq(1600, 3'b000, 1'b1);
    run_until_done(20);
    cycle();

    // Zero balance: straight to done, no coins
    start_seq(0, 3'b000, 1'b1);
    run_until_done(10);
    cycle();

    // 1000 with the 1000 hopper empty: two 500s
    start_seq(1000, 3'b100, 1'b1);
    run_until_done(20);
    cycle();

    // 250: two 100s, then short with 50 left, held in IDLE
    start_seq(250, 3'b000, 1'b1);
    run_until_done(20);
    cycle();
    cycle();
    chk("idle_busy", 32'(o_busy), 0);
    chk("idle_short_hold", 32'(o_short), 1);
    chk("idle_remaining_hold", 32'(o_remaining), 50);

    // Hopper stall for 5 cycles with a start pulse that must be ignored
    i_hopper_ready = 1'b0;
    start_seq(600, 3'b000, 1'b0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(o_coin_valid), 1);
      chk("stall_sel", 32'(o_coin_sel), 32'(3'b010));
      chk("stall_remaining", 32'(o_remaining), 600);
      chk("stall_busy", 32'(o_busy), 1);
      i_start   = (i == 2);
      i_balance = 16'd9999;
      cycle();
    end
    i_start        = 1'b0;
    i_hopper_ready = 1'b1;
    run_until_done(20);
    cycle();
    chk("stall_after_busy", 32'(o_busy), 0);
    chk("stall_after_remaining", 32'(o_remaining), 0);

    // Reset while a coin handshake is offered
    start_seq(1600, 3'b000, 1'b0);
    cycle();
    chk("pre_reset_valid", 32'(o_coin_valid), 1);
    reset_n = 1'b0;
    cycle();
    coin_q.delete();
    done_q.delete();
    reset_n = 1'b1;
    chk("post_reset_valid", 32'(o_coin_valid), 0);
    chk("post_reset_busy", 32'(o_busy), 0);
    chk("post_reset_remaining", 32'(o_remaining), 0);
    chk("post_reset_done", 32'(o_done), 0);
    cycle();
    chk("post_reset_idle_done", 32'(o_done), 0);
    start_seq(600, 3'b000, 1'b1);
    run_until_done(20);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
